// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the nibble-serial CLA adder/subtractor.
//   - NIB_W   : width of one nibble step (the CLA4 slice width)
//   - state_t : controller states
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4.sv
// ---------------------------------------------------------------------------
// cla4
//   4-bit carry-lookahead adder slice.
//   Ports:
//     i_a, i_b : 4-bit addends
//     i_ci     : carry-in
//     o_s      : 4-bit sum
//     o_co     : carry-out
//     o_pg     : group propagate (all four bits propagate)
//     o_gg     : group generate (carry produced independent of i_ci)
// ---------------------------------------------------------------------------
module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co,
  output logic       o_pg,
  output logic       o_gg
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every carry is formed directly from g/p and i_ci, no ripple.
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = o_gg | (o_pg & i_ci);

  assign o_pg = &w_p;
  assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_co = w_c[4];

endmodule

// File: rtl/cla_nibble_serial_addsub.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_addsub
//   Sequential WIDTH-bit adder/subtractor. One CLA4 slice processes one
//   nibble per clock, LSB nibble first; the carry between nibbles is held in
//   a register. Operands arrive on a valid/ready request port and the result
//   leaves on a valid/ready response port.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : request handshake (a, b, sub, ci)
//     sub                 : 0 -> s = a + b + ci, 1 -> s = a - b - ci
//     ci                  : carry-in (add) / borrow-in (sub)
//     out_valid/out_ready : response handshake (s, co, ovf, zero)
//     co                  : carry-out; in sub mode 1 means no borrow
//     ovf                 : signed overflow
//     zero                : s == 0
//   WIDTH must be a multiple of 4 and at least 8.
// ---------------------------------------------------------------------------
module cla_nibble_serial_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;

  // Operand registers shift right one nibble per step so the active nibble
  // always sits in bits [3:0]; the partial sum shifts in from the top.
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-NIB_W-1:0] r_acc;
  logic                   r_carry;

  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;
  logic             r_zero;

  logic [NIB_W-1:0] w_sum_nib;
  logic             w_co_nib;
  logic             w_unused_pg;
  logic             w_unused_gg;
  logic [WIDTH-1:0] w_s_final;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_cin_msb;

  cla4 u_cla4 (
    .i_a  (r_a[NIB_W-1:0]),
    .i_b  (r_b[NIB_W-1:0]),
    .i_ci (r_carry),
    .o_s  (w_sum_nib),
    .o_co (w_co_nib),
    .o_pg (w_unused_pg),
    .o_gg (w_unused_gg)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_step    = (r_state == ST_RUN);
  assign w_last    = (r_idx == IDX_W'(NIB - 1));

  // On the last step the current nibble is the MSB nibble, so bit 3 of the
  // active operand nibbles are the original operand sign bits.
  assign w_s_final = {w_sum_nib, r_acc};
  assign w_cin_msb = r_a[NIB_W-1] ^ r_b[NIB_W-1] ^ w_sum_nib[NIB_W-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx <= '0;
      end else if (w_step) begin
        r_idx <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_s    <= w_s_final;
          r_co   <= w_co_nib;
          r_ovf  <= w_cin_msb ^ w_co_nib;
          r_zero <= ~|w_s_final;
        end
      end
    end
  end

  // Operand / partial-sum datapath; subtraction is A + ~B + ~ci.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~ci : ci;
    end else if (w_step) begin
      r_a     <= r_a >> NIB_W;
      r_b     <= r_b >> NIB_W;
      r_acc   <= w_s_final[WIDTH-1:NIB_W];
      r_carry <= w_co_nib;
    end
  end

  assign s    = r_s;
  assign co   = r_co;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_cla_nibble_serial_addsub.sv
module tb_cla_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        co;
  logic        ovf;
  logic        zero;

  int n_chk  = 0;
  int n_fail = 0;

  cla_nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic        vci;
    logic [15:0] es;
    logic        eco;
    logic        eovf;
    logic        ezero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic msub, input logic mci,
                                output logic [15:0] es, output logic eco,
                                output logic eovf, output logic ezero);
    int ua, ub, sa, sb, r, sr, c;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    c  = mci ? 1 : 0;
    if (!msub) begin
      r   = ua + ub + c;
      sr  = sa + sb + c;
      eco = (r > 65535);
    end else begin
      r   = ua - ub - c;
      sr  = sa - sb - c;
      eco = (r >= 0);
    end
    es    = r[15:0];
    eovf  = (sr > 32767) || (sr < -32768);
    ezero = (es == 16'h0);
  endfunction

  // One complete transaction starting from #1 after a clock edge.
  task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tsub, input logic tci,
                        input logic [15:0] es, input logic eco, input logic eovf,
                        input logic ezero, input int stall);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; sub = tsub; ci = tci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ci = 1'($urandom);
    out_ready = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd4);
    chk({nm, " s"},    32'(s),    32'(es));
    chk({nm, " co"},   32'(co),   32'(eco));
    chk({nm, " ovf"},  32'(ovf),  32'(eovf));
    chk({nm, " zero"}, 32'(zero), 32'(ezero));
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
      end
      chk({nm, " held valid"}, 32'(out_valid), 32'd1);
      chk({nm, " held s"},     32'(s),         32'(es));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready rise"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, es;
    logic        rsub, rci, eco, eovf, ezero;
    int          cyc;

    vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; ci = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset s",         32'(s),         32'd0);
    chk("reset flags",     32'({co, ovf, zero}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vci,
             vecs[i].es, vecs[i].eco, vecs[i].eovf, vecs[i].ezero, i % 3);
    end

    // Backpressure: result held, new requests ignored, no same-cycle re-accept.
    a = 16'hA5A5; b = 16'h1111; sub = 1'b0; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp latency", 32'(cyc), 32'd4);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
      chk("bp in_ready",  32'(in_ready),  32'd0);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp s",         32'(s),         32'h0000B6B6);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp out_valid drop", 32'(out_valid), 32'd0);
    chk("bp in_ready rise",  32'(in_ready),  32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp no extra op", 32'(out_valid), 32'd0);
    chk("bp s kept",      32'(s),         32'h0000B6B6);

    // Reset two cycles into RUN aborts the operation.
    a = 16'h4321; b = 16'h1111; sub = 1'b0; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst-run in_ready",  32'(in_ready),  32'd1);
    chk("rst-run out_valid", 32'(out_valid), 32'd0);
    chk("rst-run s",         32'(s),         32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst-run no result", 32'(out_valid), 32'd0);
    run_op("post-rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rci = 1'($urandom);
      if (n % 10 == 0) rb = ra;
      model(ra, rb, rsub, rci, es, eco, eovf, ezero);
      run_op($sformatf("rnd%0d", n), ra, rb, rsub, rci, es, eco, eovf, ezero,
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
